icache_dm: RTL

// - Direct-mapped, read-only instruction cache between the pipeline fetch port (ICACHE_*) and the 128-bit instruction memory.
// - Serves word reads with a zero-wait hit. On a miss, stalls the fetch stage, fetches one 4-word line, refills it, then replays the access as a hit.
// - Sits directly upstream of the IF stage; the pipeline top drives proc_* from its ICACHE_* ports.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/icache_dm_if.sv | 29 ++
 rtl/icache_line_array.sv | 44 ++++
 rtl/icache_dm.sv | 100 ++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: bus widths, FSM state type and the word-select helper.
// Reused by the instruction cache and the future data cache.
package cache_pkg;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int ADDR_W         = 30;
  localparam int MEM_ADDR_W     = 28;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_e;

  // Selects word `off` from a line; word0 lives in the low 32 bits.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        off);
    return line[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-port and memory-port bundles of the instruction cache.
// master drives the request side: the pipeline on the fetch port, the cache on the memory port.
interface icache_proc_if;
  logic                        proc_read;
  logic                        proc_write;
  logic [cache_pkg::ADDR_W-1:0] proc_addr;
  logic [cache_pkg::WORD_W-1:0] proc_wdata;
  logic [cache_pkg::WORD_W-1:0] proc_rdata;
  logic                        proc_stall;

  modport master (output proc_read, proc_write, proc_addr, proc_wdata,
                  input  proc_rdata, proc_stall);
  modport slave  (input  proc_read, proc_write, proc_addr, proc_wdata,
                  output proc_rdata, proc_stall);
endinterface

interface icache_mem_if;
  logic                            mem_read;
  logic                            mem_write;
  logic [cache_pkg::MEM_ADDR_W-1:0] mem_addr;
  logic [cache_pkg::LINE_W-1:0]     mem_wdata;
  logic [cache_pkg::LINE_W-1:0]     mem_rdata;
  logic                            mem_ready;

  modport master (output mem_read, mem_write, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_read, mem_write, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache, all flops.
// One combinational read port and one synchronous write (refill) port.
module icache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = MEM_ADDR_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  logic [LINE_W-1:0]    data  [NUM_LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
      tags[wr_idx]  <= wr_tag;
      data[wr_idx]  <= wr_line;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_line  = data[rd_idx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-wait hits, one-line refill on a miss,
// then replay of the stalled fetch as a hit. Writes from the fetch port are ignored.
module icache_dm
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  icache_proc_if.slave     proc,
  icache_mem_if.master     mem,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;

  state_e                  state;
  logic [MEM_ADDR_W-1:0]   miss_addr;

  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [LINE_W-1:0]       rd_line;
  logic                    present;
  logic                    hit;
  logic                    miss;
  logic                    refill;
  logic                    unused_inputs;

  assign idx = proc.proc_addr[IDX_W+1:2];
  assign tag = proc.proc_addr[ADDR_W-1:IDX_W+2];

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (refill),
    .wr_idx   (miss_addr[IDX_W-1:0]),
    .wr_tag   (miss_addr[MEM_ADDR_W-1:IDX_W]),
    .wr_line  (mem.mem_rdata)
  );

  assign present = rd_valid && (rd_tag == tag);
  assign hit     = (state == S_IDLE) && proc.proc_read && present;
  assign miss    = (state == S_IDLE) && proc.proc_read && !present;
  assign refill  = (state == S_FETCH) && mem.mem_ready;

  assign proc.proc_stall = (state == S_FETCH) || miss;
  assign proc.proc_rdata = hit ? line_word(rd_line, proc.proc_addr[1:0]) : '0;

  // Memory side depends only on registered state, never on the fetch port.
  assign mem.mem_read  = (state == S_FETCH);
  assign mem.mem_addr  = miss_addr;
  assign mem.mem_write = 1'b0;
  assign mem.mem_wdata = '0;

  assign unused_inputs = ^{proc.proc_write, proc.proc_wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      miss_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss) begin
            miss_addr <= proc.proc_addr[ADDR_W-1:2];
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem.mem_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 1'b1;
      if (miss) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule
